// File: rtl/axi_mux_n_pkg.sv
// Shared definitions for the N-way selector: register word offsets, STATUS
// bit positions, switch FSM encoding and the AXI response code.
package axi_mux_n_pkg;

  localparam int SEL_W   = 8;
  localparam int BLANK_W = 16;

  localparam logic [15:0] REG_SEL    = 16'h0000;
  localparam logic [15:0] REG_BLANK  = 16'h0004;
  localparam logic [15:0] REG_STATUS = 16'h0008;
  localparam logic [15:0] REG_SWCNT  = 16'h000C;

  localparam int STATUS_SW_BIT  = 8;
  localparam int STATUS_OOR_BIT = 9;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    ST_PASS  = 1'b0,
    ST_BLANK = 1'b1
  } state_e;

endpackage

// File: rtl/axi_mux_n_regs.sv
// AXI4-Lite slave and register file (SEL, BLANK, STATUS, SWCNT).
// SWCNT readback exists only when AXI_MUX_N_SWCNT_EN is defined.
module axi_mux_n_regs
  import axi_mux_n_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         s_axi_awaddr,
  input  logic [2:0]          s_axi_awprot,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [31:0]         s_axi_wdata,
  input  logic [3:0]          s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [15:0]         s_axi_araddr,
  input  logic [2:0]          s_axi_arprot,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [31:0]         s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  input  logic [31:0]         status_i,
  input  logic [31:0]         swcnt_i,
  output logic [SEL_W-1:0]    sel_o,
  output logic [BLANK_W-1:0]  blank_o,
  output logic                swcnt_clr_o
);

  logic               awready_q, awready_d;
  logic               bvalid_q, bvalid_d;
  logic               arready_q, arready_d;
  logic               rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic               wr_fire, rd_fire;
  logic [31:0]        rd_mux;

  always_comb begin
    wr_fire   = awready_q & s_axi_awvalid & s_axi_wvalid;
    rd_fire   = arready_q & s_axi_arvalid;
    awready_d = ~awready_q & s_axi_awvalid & s_axi_wvalid & ~bvalid_q;
    arready_d = ~arready_q & s_axi_arvalid & ~rvalid_q;

    bvalid_d = bvalid_q;
    if (wr_fire)           bvalid_d = 1'b1;
    else if (s_axi_bready) bvalid_d = 1'b0;

    rvalid_d = rvalid_q;
    if (rd_fire)           rvalid_d = 1'b1;
    else if (s_axi_rready) rvalid_d = 1'b0;

    sel_d       = sel_q;
    blank_d     = blank_q;
    swcnt_clr_o = 1'b0;
    if (wr_fire) begin
      case (s_axi_awaddr[15:2])
        REG_SEL[15:2]: if (s_axi_wstrb[0]) sel_d = s_axi_wdata[7:0];
        REG_BLANK[15:2]: begin
          if (s_axi_wstrb[0]) blank_d[7:0]  = s_axi_wdata[7:0];
          if (s_axi_wstrb[1]) blank_d[15:8] = s_axi_wdata[15:8];
        end
        REG_SWCNT[15:2]: swcnt_clr_o = 1'b1;
        default: ;
      endcase
    end

    // Reads sample the register state before this edge's write lands.
    rd_mux = '0;
    case (s_axi_araddr[15:2])
      REG_SEL[15:2]:    rd_mux = {24'd0, sel_q};
      REG_BLANK[15:2]:  rd_mux = {16'd0, blank_q};
      REG_STATUS[15:2]: rd_mux = status_i;
`ifdef AXI_MUX_N_SWCNT_EN
      REG_SWCNT[15:2]:  rd_mux = swcnt_i;
`endif
      default: ;
    endcase
    rdata_d = rd_fire ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      sel_q     <= '0;
      blank_q   <= '0;
    end else begin
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      sel_q     <= sel_d;
      blank_q   <= blank_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = RESP_OKAY;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = RESP_OKAY;
  assign sel_o         = sel_q;
  assign blank_o       = blank_q;

  logic unused_bits;
`ifdef AXI_MUX_N_SWCNT_EN
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0],
                         s_axi_wdata[31:16], s_axi_wstrb[3:2]};
`else
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0],
                         s_axi_wdata[31:16], s_axi_wstrb[3:2], swcnt_i};
`endif

endmodule

// File: rtl/axi_mux_n.sv
// N-way registered selector with blanking switch FSM and AXI4-Lite control.
// Define AXI_MUX_N_SWCNT_EN to build the completed-switch counter (SWCNT).
module axi_mux_n
  import axi_mux_n_pkg::*;
#(
  parameter int C_DATA_W     = 1,
  parameter int C_NUM_INPUTS = 8
) (
  input  logic                             s_axi_aclk,
  input  logic                             s_axi_areset,
  input  logic [15:0]                      s_axi_awaddr,
  input  logic [2:0]                       s_axi_awprot,
  input  logic                             s_axi_awvalid,
  output logic                             s_axi_awready,
  input  logic [31:0]                      s_axi_wdata,
  input  logic [3:0]                       s_axi_wstrb,
  input  logic                             s_axi_wvalid,
  output logic                             s_axi_wready,
  output logic [1:0]                       s_axi_bresp,
  output logic                             s_axi_bvalid,
  input  logic                             s_axi_bready,
  input  logic [15:0]                      s_axi_araddr,
  input  logic [2:0]                       s_axi_arprot,
  input  logic                             s_axi_arvalid,
  output logic                             s_axi_arready,
  output logic [31:0]                      s_axi_rdata,
  output logic [1:0]                       s_axi_rresp,
  output logic                             s_axi_rvalid,
  input  logic                             s_axi_rready,
  input  logic [C_NUM_INPUTS*C_DATA_W-1:0] din,
  output logic [C_DATA_W-1:0]              dout,
  output logic                             switching
);

  logic [SEL_W-1:0]   sel;
  logic [BLANK_W-1:0] blank;
  logic               swcnt_clr, swcnt_inc, oor;
  logic [31:0]        status, swcnt;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    active_q, active_d;
  logic [BLANK_W-1:0]  cnt_q, cnt_d;
  logic                switching_q, switching_d;
  logic [C_DATA_W-1:0] dout_q, dout_d;
  logic [C_DATA_W-1:0] active_data, sel_data;

  axi_mux_n_regs u_regs (
    .clk(s_axi_aclk), .rst(s_axi_areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .status_i(status), .swcnt_i(swcnt),
    .sel_o(sel), .blank_o(blank), .swcnt_clr_o(swcnt_clr)
  );

  // Out-of-range indices match no input and therefore select zero.
  always_comb begin
    active_data = '0;
    sel_data    = '0;
    for (int k = 0; k < C_NUM_INPUTS; k++) begin
      if (active_q == k[SEL_W-1:0]) active_data = din[k*C_DATA_W +: C_DATA_W];
      if (sel == k[SEL_W-1:0])      sel_data    = din[k*C_DATA_W +: C_DATA_W];
    end
    oor = (active_q >= SEL_W'(C_NUM_INPUTS));
    status = '0;
    status[SEL_W-1:0]     = active_q;
    status[STATUS_SW_BIT]  = switching_q;
    status[STATUS_OOR_BIT] = oor;
  end

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    cnt_d       = cnt_q;
    switching_d = switching_q;
    dout_d      = dout_q;
    swcnt_inc   = 1'b0;
    case (state_q)
      ST_PASS: begin
        dout_d = active_data;
        if (sel != active_q) begin
          if (blank == '0) begin
            active_d  = sel;
            swcnt_inc = 1'b1;
          end else begin
            state_d     = ST_BLANK;
            cnt_d       = blank;
            switching_d = 1'b1;
            dout_d      = '0;
          end
        end
      end
      ST_BLANK: begin
        dout_d = '0;
        cnt_d  = cnt_q - 1'b1;
        // The exit edge loads the new source directly so the gap is exactly BLANK cycles.
        if (cnt_q == 16'd1) begin
          state_d     = ST_PASS;
          active_d    = sel;
          switching_d = 1'b0;
          dout_d      = sel_data;
          swcnt_inc   = 1'b1;
        end
      end
      default: state_d = ST_PASS;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state_q     <= ST_PASS;
      active_q    <= '0;
      cnt_q       <= '0;
      switching_q <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      cnt_q       <= cnt_d;
      switching_q <= switching_d;
      dout_q      <= dout_d;
    end
  end

`ifdef AXI_MUX_N_SWCNT_EN
  logic [31:0] swcnt_q, swcnt_d;

  always_comb begin
    swcnt_d = swcnt_q;
    if (swcnt_clr)      swcnt_d = '0;
    else if (swcnt_inc) swcnt_d = swcnt_q + 32'd1;
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) swcnt_q <= '0;
    else              swcnt_q <= swcnt_d;
  end

  assign swcnt = swcnt_q;
`else
  logic unused_swcnt;
  assign unused_swcnt = swcnt_clr ^ swcnt_inc;
  assign swcnt        = '0;
`endif

  assign dout      = dout_q;
  assign switching = switching_q;

endmodule

// File: tb/tb_axi_mux_n.sv
// Directed bench for axi_mux_n (8 inputs x 8 bits, din[k] = 8'h10 + k).
// SWCNT expectations follow AXI_MUX_N_SWCNT_EN.
module tb_axi_mux_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [63:0] din;
  logic [7:0]  dout;
  logic        switching;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  axi_mux_n #(.C_DATA_W(8), .C_NUM_INPUTS(8)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .din(din), .dout(dout), .switching(switching)
  );

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    int cyc;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    cyc = 0;
    while (!awready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!awready) begin
      n_cmp++; n_mis++;
      $display("FAIL write_timeout addr=%h awready=%b required 1", a, awready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    $display("write addr=%h data=%h strb=%b", a, d, s);
  endtask

  task automatic axi_read(input logic [15:0] a, output logic [31:0] d);
    int cyc;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    cyc = 0;
    while (!arready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    cyc = 0;
    while (!rvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!rvalid) begin
      n_cmp++; n_mis++;
      $display("FAIL read_timeout addr=%h rvalid=%b required 1", a, rvalid);
      d = '0;
    end else begin
      d = rdata;
    end
    @(posedge clk); #1;
    $display("read  addr=%h data=%h", a, d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({awready, wready, bvalid, arready, rvalid, switching, dout, rdata, bresp, rresp} !== '0) begin
      n_mis++;
      $display("FAIL reset_outputs got aw=%b w=%b b=%b ar=%b r=%b sw=%b dout=%h rdata=%h required all 0",
               awready, wready, bvalid, arready, rvalid, switching, dout, rdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (dout !== 8'h10) begin n_mis++; $display("FAIL reset_dout0 got %h required 10", dout); end
  endtask

  task automatic test_regs();
    logic [31:0] r;
    axi_write(16'h0004, 32'h0000_1234, 4'b0011);
    axi_write(16'h0004, 32'h0000_AB00, 4'b0010);
    axi_read(16'h0004, r);
    n_cmp++;
    if (r !== 32'h0000_AB34) begin n_mis++; $display("FAIL blank_wstrb got %h required 0000ab34", r); end
    axi_read(16'h0010, r);
    n_cmp++;
    if (r !== 32'h0) begin n_mis++; $display("FAIL unmapped_read got %h required 0", r); end
    axi_write(16'h0004, 32'h0, 4'b1111);
  endtask

  task automatic test_immediate();
    logic [31:0] r;
    axi_write(16'h0000, 32'd3, 4'b0001);
    @(posedge clk); #1;
    n_cmp++;
    if (dout !== 8'h10) begin n_mis++; $display("FAIL imm_edge1 got %h required 10", dout); end
    @(posedge clk); #1;
    n_cmp++;
    if (dout !== 8'h13) begin n_mis++; $display("FAIL imm_edge2 got %h required 13", dout); end
    axi_read(16'h0008, r);
    n_cmp++;
    if (r !== 32'h003) begin n_mis++; $display("FAIL imm_status got %h required 003", r); end
  endtask

  task automatic test_blank5();
    logic [31:0] r;
    int zeros, sws;
    logic [7:0] d6;
    axi_write(16'h0004, 32'd5, 4'b0011);
    axi_write(16'h0000, 32'd6, 4'b0001);
    zeros = 0; sws = 0; d6 = '0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (dout == 8'h00) zeros++;
      if (switching) sws++;
      if (k == 6) d6 = dout;
    end
    n_cmp++;
    if (zeros != 5) begin n_mis++; $display("FAIL blank5_zeros got %0d required 5", zeros); end
    n_cmp++;
    if (sws != 5) begin n_mis++; $display("FAIL blank5_switching got %0d required 5", sws); end
    n_cmp++;
    if (d6 !== 8'h16) begin n_mis++; $display("FAIL blank5_exit got %h required 16", d6); end
    axi_read(16'h0008, r);
    n_cmp++;
    if (r !== 32'h006) begin n_mis++; $display("FAIL blank5_status got %h required 006", r); end
  endtask

  task automatic test_retarget();
    int zeros;
    logic [7:0] d11;
    axi_write(16'h0004, 32'd10, 4'b0011);
    axi_write(16'h0000, 32'd2, 4'b0001);
    zeros = 0; d11 = '0;
    fork
      begin
        for (int k = 1; k <= 14; k++) begin
          @(posedge clk); #1;
          if (dout == 8'h00) zeros++;
          if (k == 11) d11 = dout;
        end
      end
      begin
        repeat (2) @(posedge clk);
        axi_write(16'h0000, 32'd4, 4'b0001);
      end
    join
    n_cmp++;
    if (zeros != 10) begin n_mis++; $display("FAIL retarget_zeros got %0d required 10", zeros); end
    n_cmp++;
    if (d11 !== 8'h14) begin n_mis++; $display("FAIL retarget_exit got %h required 14", d11); end
  endtask

  task automatic test_oor_bstall();
    logic [31:0] r;
    axi_write(16'h0004, 32'd0, 4'b0011);
    axi_write(16'h0000, 32'd9, 4'b0001);
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (dout !== 8'h00) begin n_mis++; $display("FAIL oor_dout got %h required 00", dout); end
    axi_read(16'h0008, r);
    n_cmp++;
    if (r !== 32'h209) begin n_mis++; $display("FAIL oor_status got %h required 209", r); end
    bready = 1'b0;
    axi_write(16'h0004, 32'd7, 4'b0011);
    @(negedge clk);
    awaddr = 16'h0004; wdata = 32'd3; wstrb = 4'b0011; awvalid = 1'b1; wvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bvalid !== 1'b1 || awready !== 1'b0) begin
        n_mis++;
        $display("FAIL bstall_cycle%0d got bvalid=%b awready=%b required 1/0", k, bvalid, awready);
      end
    end
    bready = 1'b1;
    axi_write(16'h0004, 32'd3, 4'b0011);
    axi_read(16'h0004, r);
    n_cmp++;
    if (r !== 32'd3) begin n_mis++; $display("FAIL bstall_blank got %h required 3", r); end
  endtask

  task automatic test_swcnt();
    logic [31:0] r, exp3;
`ifdef AXI_MUX_N_SWCNT_EN
    exp3 = 32'd3;
`else
    exp3 = 32'd0;
`endif
    axi_write(16'h0004, 32'd0, 4'b0011);
    axi_write(16'h000C, 32'd0, 4'b1111);
    for (int k = 1; k <= 3; k++) begin
      axi_write(16'h0000, k, 4'b0001);
      repeat (2) @(posedge clk);
    end
    #1;
    n_cmp++;
    if (dout !== 8'h13) begin n_mis++; $display("FAIL swcnt_dout got %h required 13", dout); end
    axi_read(16'h000C, r);
    n_cmp++;
    if (r !== exp3) begin n_mis++; $display("FAIL swcnt_three got %h required %h", r, exp3); end
    axi_write(16'h000C, 32'd0, 4'b1111);
    axi_read(16'h000C, r);
    n_cmp++;
    if (r !== 32'd0) begin n_mis++; $display("FAIL swcnt_clear got %h required 0", r); end
  endtask

  task automatic test_reset_mid_blank();
    logic [31:0] r;
    axi_write(16'h0004, 32'd20, 4'b0011);
    axi_write(16'h0000, 32'd5, 4'b0001);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (switching !== 1'b0 || dout !== 8'h00) begin
      n_mis++;
      $display("FAIL async_reset got sw=%b dout=%h required 0/00", switching, dout);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (dout !== 8'h10) begin n_mis++; $display("FAIL post_reset_dout got %h required 10", dout); end
    axi_read(16'h0008, r);
    n_cmp++;
    if (r !== 32'h0) begin n_mis++; $display("FAIL post_reset_status got %h required 0", r); end
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; bready = 1'b1; rready = 1'b1;
    for (int k = 0; k < 8; k++) din[k*8 +: 8] = 8'h10 + k[7:0];
    test_reset();
    test_regs();
    test_immediate();
    test_blank5();
    test_retarget();
    test_oor_bstall();
    test_swcnt();
    test_reset_mid_blank();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
